// File: rtl/mdmhc_pkg.sv
// -----------------------------------------------------------------------------
// mdmhc_pkg
// Shared definitions for the MDMHC encoder and decoder paths: codeword and
// data widths, field offsets inside the 68-bit codeword, symbol and
// horizontal-parity widths, the per-word status enum, and the symbol-pair sum
// that both sides use to build and check horizontal parity.
//
// Codeword layout:
//   [31:0]  d   data
//   [47:32] v   vertical parity, v[j] = d[j] ^ d[j+16]
//   [52:48] h0  s0 + s2
//   [57:53] h1  s1 + s3
//   [62:58] h2  s4 + s6
//   [67:63] h3  s5 + s7
// where sN = d[4N+3:4N].
// -----------------------------------------------------------------------------
package mdmhc_pkg;

    localparam int CODE_W = 68;
    localparam int DATA_W = 32;
    localparam int SYM_W  = 4;
    localparam int HP_W   = 5;
    localparam int V_W    = 16;
    localparam int NUM_H  = 4;

    localparam int D_LSB  = 0;
    localparam int V_LSB  = 32;
    localparam int H0_LSB = 48;
    localparam int H1_LSB = 53;
    localparam int H2_LSB = 58;
    localparam int H3_LSB = 63;

    typedef enum logic [1:0] {
        CLEAN         = 2'd0,
        CORRECTED     = 2'd1,
        UNCORRECTABLE = 2'd2
    } status_e;

    // Sum of two 4-bit symbols carried at 5 bits so the carry is kept.
    function automatic logic [HP_W-1:0] symPairSum(input logic [DATA_W-1:0] d,
                                                   input int                a,
                                                   input int                b);
        symPairSum = HP_W'(d[SYM_W*a +: SYM_W]) + HP_W'(d[SYM_W*b +: SYM_W]);
    endfunction

endpackage

// File: rtl/mdmhc_syndrome.sv
// -----------------------------------------------------------------------------
// mdmhc_syndrome
// Purely combinational syndrome generator for an MDMHC codeword. Shared by
// the decoder's first pipeline stage and by link self-test logic.
//
// Ports:
//   code_i  [67:0]  incoming codeword
//   vsyn_o  [15:0]  vertical syndrome, d[j] ^ d[j+16] ^ v[j]
//   m_o     [3:0]   horizontal mismatch flags, one per h field
// -----------------------------------------------------------------------------
module mdmhc_syndrome
    import mdmhc_pkg::*;
(
    input  logic [CODE_W-1:0] code_i,
    output logic [V_W-1:0]    vsyn_o,
    output logic [NUM_H-1:0]  m_o
);

    logic [DATA_W-1:0] dataField;
    logic [V_W-1:0]    vertField;

    assign dataField = code_i[D_LSB +: DATA_W];
    assign vertField = code_i[V_LSB +: V_W];

    assign vsyn_o = dataField[V_W-1:0] ^ dataField[DATA_W-1:V_W] ^ vertField;

    // Rows 0/1 pair symbols within the low half, rows 2/3 within the high half.
    assign m_o[0] = symPairSum(dataField, 0, 2) != code_i[H0_LSB +: HP_W];
    assign m_o[1] = symPairSum(dataField, 1, 3) != code_i[H1_LSB +: HP_W];
    assign m_o[2] = symPairSum(dataField, 4, 6) != code_i[H2_LSB +: HP_W];
    assign m_o[3] = symPairSum(dataField, 5, 7) != code_i[H3_LSB +: HP_W];

endmodule

// File: rtl/mdmhc_decoder.sv
// -----------------------------------------------------------------------------
// mdmhc_decoder
// Two-stage receive pipeline for MDMHC codewords. Stage 1 registers the data
// together with its vertical syndrome and horizontal mismatch flags; stage 2
// locates and flips single-bit data errors, classifies the word and holds the
// registered result until the consumer takes it.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  upstream handshake
//   in_code   [67:0]   codeword
//   out_valid/out_ready downstream handshake
//   out_data  [31:0]   corrected (or raw, if uncorrectable) data
//   out_corrected      an error was found and resolved
//   out_uncorrectable  an error was found that could not be resolved
//
// Optional build macro MDMHC_DEC_ERR_CNT_EN adds saturating counters:
//   cnt_clr            clears both counters, beats a same-cycle increment
//   corr_cnt   [CNT_W-1:0] delivered words flagged corrected
//   uncorr_cnt [CNT_W-1:0] delivered words flagged uncorrectable
// -----------------------------------------------------------------------------
module mdmhc_decoder
    import mdmhc_pkg::*;
`ifdef MDMHC_DEC_ERR_CNT_EN
#(
    parameter int CNT_W = 16
)
`endif
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_corrected,
    output logic              out_uncorrectable
`ifdef MDMHC_DEC_ERR_CNT_EN
    ,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
`endif
);

    logic [V_W-1:0]    vsynIn;
    logic [NUM_H-1:0]  mIn;

    logic              s1Valid_q;
    logic [DATA_W-1:0] s1Data_q;
    logic [V_W-1:0]    s1Vsyn_q;
    logic [NUM_H-1:0]  s1M_q;

    logic              s2Valid_q;
    logic [DATA_W-1:0] outData_q, outData_d;
    logic              outCorr_q, outCorr_d;
    logic              outUncorr_q, outUncorr_d;

    logic              s2Load;
    logic              s1Load;
    logic [DATA_W-1:0] fixedData;
    logic              unresolved;
    logic              rowLo;
    logic              rowHi;
    status_e           status;

    mdmhc_syndrome u_syndrome (
        .code_i (in_code),
        .vsyn_o (vsynIn),
        .m_o    (mIn)
    );

    // Stage 2 may load when empty or draining; stage 1 when empty or
    // handing its word to stage 2 this cycle.
    assign s2Load   = !s2Valid_q || out_ready;
    assign s1Load   = !s1Valid_q || s2Load;
    assign in_ready = s1Load;

    // Each set vertical syndrome bit names a column; the row check for that
    // column's symbol tells whether the low-half or high-half bit is wrong.
    always_comb begin
        fixedData  = s1Data_q;
        unresolved = 1'b0;
        rowLo      = 1'b0;
        rowHi      = 1'b0;
        for (int j = 0; j < V_W; j++) begin
            if (s1Vsyn_q[j]) begin
                rowLo = ((j / SYM_W) % 2 == 0) ? s1M_q[0] : s1M_q[1];
                rowHi = ((j / SYM_W) % 2 == 0) ? s1M_q[2] : s1M_q[3];
                if (rowLo && !rowHi) begin
                    fixedData[j] = ~s1Data_q[j];
                end else if (rowHi && !rowLo) begin
                    fixedData[j+V_W] = ~s1Data_q[j+V_W];
                end else begin
                    unresolved = 1'b1;
                end
            end
        end
    end

    // Classification; a lone vertical or lone horizontal fault means the
    // parity field itself was hit, so the data needs no flip.
    always_comb begin
        status = CLEAN;
        if (s1Vsyn_q == '0) begin
            if (s1M_q == '0) begin
                status = CLEAN;
            end else if ($onehot(s1M_q)) begin
                status = CORRECTED;
            end else begin
                status = UNCORRECTABLE;
            end
        end else if (s1M_q == '0) begin
            status = CORRECTED;
        end else begin
            status = unresolved ? UNCORRECTABLE : CORRECTED;
        end
    end

    // Vertical-only faults leave fixedData equal to the raw word, so only the
    // uncorrectable case has to fall back to raw data explicitly.
    always_comb begin
        outData_d   = (status == UNCORRECTABLE) ? s1Data_q : fixedData;
        outCorr_d   = (status == CORRECTED);
        outUncorr_d = (status == UNCORRECTABLE);
    end

    // Pipeline registers; stalled stages simply keep their contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid_q   <= 1'b0;
            s1Data_q    <= '0;
            s1Vsyn_q    <= '0;
            s1M_q       <= '0;
            s2Valid_q   <= 1'b0;
            outData_q   <= '0;
            outCorr_q   <= 1'b0;
            outUncorr_q <= 1'b0;
        end else begin
            if (s1Load) begin
                s1Valid_q <= in_valid;
            end
            if (s1Load && in_valid) begin
                s1Data_q <= in_code[D_LSB +: DATA_W];
                s1Vsyn_q <= vsynIn;
                s1M_q    <= mIn;
            end
            if (s2Load) begin
                s2Valid_q <= s1Valid_q;
            end
            if (s2Load && s1Valid_q) begin
                outData_q   <= outData_d;
                outCorr_q   <= outCorr_d;
                outUncorr_q <= outUncorr_d;
            end
        end
    end

    assign out_valid         = s2Valid_q;
    assign out_data          = outData_q;
    assign out_corrected     = outCorr_q;
    assign out_uncorrectable = outUncorr_q;

`ifdef MDMHC_DEC_ERR_CNT_EN
    logic [CNT_W-1:0] corrCnt_q;
    logic [CNT_W-1:0] uncorrCnt_q;
    logic             outFire;

    assign outFire = s2Valid_q && out_ready;

    // Counters advance only on a delivered word and stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corrCnt_q   <= '0;
            uncorrCnt_q <= '0;
        end else if (cnt_clr) begin
            corrCnt_q   <= '0;
            uncorrCnt_q <= '0;
        end else if (outFire) begin
            if (outCorr_q && (corrCnt_q != '1)) begin
                corrCnt_q <= corrCnt_q + CNT_W'(1);
            end
            if (outUncorr_q && (uncorrCnt_q != '1)) begin
                uncorrCnt_q <= uncorrCnt_q + CNT_W'(1);
            end
        end
    end

    assign corr_cnt   = corrCnt_q;
    assign uncorr_cnt = uncorrCnt_q;
`endif

endmodule

// File: tb/tb_mdmhc_decoder.sv
// -----------------------------------------------------------------------------
// tb_mdmhc_decoder
// Directed, table-driven bench for mdmhc_decoder. Codewords are built by a
// small local encoder; expected outputs are hand-computed constants. With
// MDMHC_DEC_ERR_CNT_EN defined the DUT is built with CNT_W=2 so saturation
// is reachable.
// -----------------------------------------------------------------------------
module tb_mdmhc_decoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [67:0] in_code;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_corrected;
    logic        out_uncorrectable;

    int checkCount;
    int errorCount;

`ifdef MDMHC_DEC_ERR_CNT_EN
    logic       cnt_clr;
    logic [1:0] corr_cnt;
    logic [1:0] uncorr_cnt;

    mdmhc_decoder #(.CNT_W(2)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_code           (in_code),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_corrected     (out_corrected),
        .out_uncorrectable (out_uncorrectable),
        .cnt_clr           (cnt_clr),
        .corr_cnt          (corr_cnt),
        .uncorr_cnt        (uncorr_cnt)
    );
`else
    mdmhc_decoder dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_code           (in_code),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_corrected     (out_corrected),
        .out_uncorrectable (out_uncorrectable)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic [67:0] flip;
        logic [31:0] expData;
        logic        expCorr;
        logic        expUncorr;
    } vec_t;

    vec_t vecs[11];

    // Independent encoder: vertical parity folds the halves, horizontal
    // parity sums symbol pairs at 5 bits.
    function automatic logic [67:0] encode(input logic [31:0] d);
        logic [4:0] h0, h1, h2, h3;
        h0 = {1'b0, d[3:0]}   + {1'b0, d[11:8]};
        h1 = {1'b0, d[7:4]}   + {1'b0, d[15:12]};
        h2 = {1'b0, d[19:16]} + {1'b0, d[27:24]};
        h3 = {1'b0, d[23:20]} + {1'b0, d[31:28]};
        return {h3, h2, h1, h0, d[15:0] ^ d[31:16], d};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Presents one codeword with out_ready high, waits for its result and
    // lets it drain. ok drops if either wait runs out.
    task automatic applyStimulus(input logic [67:0] code, output logic [31:0] data,
                                 output logic corr, output logic uncorr, output logic ok);
        int waited;
        ok       = 1'b1;
        in_code  = code;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 10) begin
            step();
            waited++;
        end
        if (waited >= 10) ok = 1'b0;
        step();
        in_valid = 1'b0;
        waited   = 0;
        while (!out_valid && waited < 10) begin
            step();
            waited++;
        end
        if (!out_valid) ok = 1'b0;
        data   = out_data;
        corr   = out_corrected;
        uncorr = out_uncorrectable;
        step();
    endtask

    logic [31:0] gotData;
    logic        gotCorr;
    logic        gotUncorr;
    logic        gotOk;
    logic [31:0] bpData[4];
    int          sent;
    int          got;
    logic        inFire;

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_code    = '0;
        out_ready  = 1'b1;
`ifdef MDMHC_DEC_ERR_CNT_EN
        cnt_clr    = 1'b0;
`endif

        vecs[0]  = '{"clean",        32'h12345678, 68'd0,                          32'h12345678, 1'b0, 1'b0};
        vecs[1]  = '{"flip_d5",      32'h12345678, 68'd1 << 5,                     32'h12345678, 1'b1, 1'b0};
        vecs[2]  = '{"flip_d21",     32'h12345678, 68'd1 << 21,                    32'h12345678, 1'b1, 1'b0};
        vecs[3]  = '{"flip_v3",      32'h12345678, 68'd1 << 35,                    32'h12345678, 1'b1, 1'b0};
        vecs[4]  = '{"flip_h2b0",    32'h12345678, 68'd1 << 58,                    32'h12345678, 1'b1, 1'b0};
        vecs[5]  = '{"flip_d5_d21",  32'h12345678, (68'd1 << 5) | (68'd1 << 21),   32'h12145658, 1'b0, 1'b1};
        vecs[6]  = '{"clean_ones",   32'hFFFFFFFF, 68'd0,                          32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[7]  = '{"flip_d0_d20",  32'hDEADBEEF, (68'd1 << 0) | (68'd1 << 20),   32'hDEADBEEF, 1'b1, 1'b0};
        vecs[8]  = '{"flip_d0_h2",   32'h12345678, (68'd1 << 0) | (68'd1 << 58),   32'h12345679, 1'b0, 1'b1};
        vecs[9]  = '{"flip_h0_h1",   32'h12345678, (68'd1 << 48) | (68'd1 << 53),  32'h12345678, 1'b0, 1'b1};
        vecs[10] = '{"flip_d31",     32'h00000000, 68'd1 << 31,                    32'h00000000, 1'b1, 1'b0};

        // Reset state
        step();
        step();
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", out_data, 32'd0);
        checkOutput("rst_corr", 32'(out_corrected), 32'd0);
        checkOutput("rst_uncorr", 32'(out_uncorrectable), 32'd0);
        rst_n = 1'b1;
        step();
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back clean words: first result two cycles on, no gaps
        for (int c = 0; c < 12; c++) begin
            in_valid = (c < 8);
            in_code  = encode(32'h12345678);
            #1;
            checkOutput($sformatf("b2b_valid_%0d", c), 32'(out_valid), 32'((c >= 2) && (c < 10)));
            if ((c >= 2) && (c < 10)) begin
                checkOutput($sformatf("b2b_data_%0d", c), out_data, 32'h12345678);
                checkOutput($sformatf("b2b_flags_%0d", c),
                            32'({out_corrected, out_uncorrectable}), 32'd0);
            end
            step();
        end
        in_valid = 1'b0;

        // Table of single-word error patterns
        for (int i = 0; i < 11; i++) begin
            applyStimulus(encode(vecs[i].data) ^ vecs[i].flip, gotData, gotCorr, gotUncorr, gotOk);
            checkOutput({vecs[i].name, "_handshake"}, 32'(gotOk), 32'd1);
            checkOutput({vecs[i].name, "_data"}, gotData, vecs[i].expData);
            checkOutput({vecs[i].name, "_corr"}, 32'(gotCorr), 32'(vecs[i].expCorr));
            checkOutput({vecs[i].name, "_uncorr"}, 32'(gotUncorr), 32'(vecs[i].expUncorr));
        end

        // Backpressure: out_ready low for five cycles while four words are offered
        bpData[0] = 32'hA0A0A0A1;
        bpData[1] = 32'hB1B2B3B4;
        bpData[2] = 32'hC3C3C3C3;
        bpData[3] = 32'hD0D1D2D3;
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            in_valid  = (sent < 4);
            in_code   = (sent < 4) ? encode(bpData[sent]) : '0;
            out_ready = (cyc >= 5);
            #1;
            if (cyc == 4) begin
                checkOutput("bp_accepted", 32'(sent), 32'd2);
                checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
                checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
                checkOutput("bp_hold_data", out_data, bpData[0]);
            end
            inFire = in_valid && in_ready;
            if (out_valid && out_ready) begin
                checkOutput($sformatf("bp_order_%0d", got), out_data, bpData[got]);
                got++;
            end
            step();
            if (inFire) sent++;
        end
        in_valid = 1'b0;
        checkOutput("bp_received", 32'(got), 32'd4);
        checkOutput("bp_sent", 32'(sent), 32'd4);
        checkOutput("bp_no_dup", 32'(out_valid), 32'd0);

        // Reset while both stages hold words
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = encode(32'h12345678);
        step();
        in_code   = encode(32'h0F0F0F0F) ^ (68'd1 << 2);
        step();
        in_valid  = 1'b0;
        checkOutput("full_out_valid", 32'(out_valid), 32'd1);
        checkOutput("full_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_out_data", out_data, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        checkOutput("postrst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("postrst_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;

`ifdef MDMHC_DEC_ERR_CNT_EN
        checkOutput("cnt_rst_corr", 32'(corr_cnt), 32'd0);
        checkOutput("cnt_rst_uncorr", 32'(uncorr_cnt), 32'd0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(encode(32'h12345678) ^ (68'd1 << 5), gotData, gotCorr, gotUncorr, gotOk);
        end
        checkOutput("cnt_sat_corr", 32'(corr_cnt), 32'd3);
        checkOutput("cnt_sat_uncorr", 32'(uncorr_cnt), 32'd0);
        applyStimulus(encode(32'h12345678) ^ (68'd1 << 48) ^ (68'd1 << 53),
                      gotData, gotCorr, gotUncorr, gotOk);
        checkOutput("cnt_uncorr_one", 32'(uncorr_cnt), 32'd1);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        checkOutput("cnt_clr_corr", 32'(corr_cnt), 32'd0);
        checkOutput("cnt_clr_uncorr", 32'(uncorr_cnt), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
